// File: rtl/data_mem_responder.sv
// Wait-state data memory responder for the pipeline MEM stage: 32-bit word storage with byte/half lanes.
// Define DMR_ALIGN_CHECK_EN to flag and suppress misaligned half/word accesses via AddrErr.
module data_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH_LOG2  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req,
    input  logic        WrEn,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    output logic        Busy,
    output logic        Ack,
    output logic [31:0] RdData,
    output logic        AddrErr
);

    // state   | meaning
    // ST_IDLE | ready, accepts Req
    // ST_WAIT | counting wait states down to zero
    // ST_RESP | single Ack cycle, store commits on its closing edge
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    latch_en;
    logic                    wr_q;
    logic [DEPTH_LOG2+1:0]   addr_q;
    logic [31:0]             wdata_q;
    logic [1:0]              size_q;
    logic                    uns_q;

    logic [31:0]             mem [0:(2**DEPTH_LOG2)-1];
    logic [DEPTH_LOG2-1:0]   word_idx;
    logic [31:0]             rd_word;
    logic                    is_half, is_byte;
    logic                    misalign;
    logic [7:0]              byte_sel;
    logic [15:0]             half_sel;
    logic [31:0]             load_val;
    logic [3:0]              be;
    logic [31:0]             wd;
    logic                    do_write;
    logic                    unused_addr;

    assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (latch_en) begin
                wr_q    <= WrEn;
                addr_q  <= Addr[DEPTH_LOG2+1:0];
                wdata_q <= WrData;
                size_q  <= Size;
                uns_q   <= Unsigned;
            end
        end
    end

    // WAIT exits when the counter is already zero, giving WAIT_CYCLES+1 cycles to Ack.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        latch_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Req) begin
                    latch_en = 1'b1;
                    if (WAIT_INIT == 4'd0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    assign word_idx = addr_q[DEPTH_LOG2+1:2];
    assign rd_word  = mem[word_idx];
    assign is_half  = (size_q == 2'b01);
    assign is_byte  = (size_q == 2'b10);

`ifdef DMR_ALIGN_CHECK_EN
    assign misalign = (is_half && addr_q[0]) ||
                      (!is_half && !is_byte && (addr_q[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        byte_sel = rd_word[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = rd_word[7:0];
            2'b01: byte_sel = rd_word[15:8];
            2'b10: byte_sel = rd_word[23:16];
            2'b11: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    assign half_sel = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        be       = 4'b1111;
        wd       = wdata_q;
        if (is_half) begin
            load_val = uns_q ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
            be       = addr_q[1] ? 4'b1100 : 4'b0011;
            wd       = {2{wdata_q[15:0]}};
        end else if (is_byte) begin
            load_val = uns_q ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            be       = 4'b0001 << addr_q[1:0];
            wd       = {4{wdata_q[7:0]}};
        end
    end

    // Storage has no reset; an asynchronous reset forces IDLE so an aborted store never commits.
    assign do_write = (state_q == ST_RESP) && wr_q && !misalign;

    always_ff @(posedge Clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[word_idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
    end

    assign Ack     = (state_q == ST_RESP);
    assign Busy    = (state_q != ST_IDLE);
    assign AddrErr = Ack && misalign;
    assign RdData  = (Ack && !wr_q && !misalign) ? load_val : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: WAIT_CYCLES=2 instance plus a WAIT_CYCLES=0 instance.
// Expected alignment behaviour follows DMR_ALIGN_CHECK_EN as defined for the build.
module tb_data_mem_responder;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        Req = 1'b0, WrEn = 1'b0, Unsigned = 1'b0;
    logic [31:0] Addr = 32'd0, WrData = 32'd0;
    logic [1:0]  Size = 2'b00;
    logic        Busy, Ack, AddrErr;
    logic [31:0] RdData;

    logic        req0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
    logic        busy0, ack0, err0;
    logic [31:0] rd0;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 Clk = ~Clk;

    data_mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(10)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .WrEn(WrEn), .Addr(Addr), .WrData(WrData),
        .Size(Size), .Unsigned(Unsigned), .Busy(Busy), .Ack(Ack), .RdData(RdData), .AddrErr(AddrErr)
    );

    data_mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(10)) dut0 (
        .Clk(Clk), .Rst(Rst), .Req(req0), .WrEn(wr0), .Addr(addr0), .WrData(wdata0),
        .Size(2'b00), .Unsigned(1'b0), .Busy(busy0), .Ack(ack0), .RdData(rd0), .AddrErr(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=2 instance; returns the Ack-cycle outputs and latency.
    task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic u,
                        output logic [31:0] rd, output logic err, output int lat);
        @(negedge Clk);
        Req = 1'b1; WrEn = wr; Addr = a; WrData = d; Size = sz; Unsigned = u;
        @(posedge Clk);
        #1 Req = 1'b0;
        lat = 0;
        rd  = 32'd0;
        err = 1'b0;
        do begin
            @(posedge Clk);
            #1 lat++;
        end while (!Ack && lat < 20);
        if (!Ack) check("ack_timeout", 32'(lat), 32'd3);
        rd  = RdData;
        err = AddrErr;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          ack_n;
        int          first_ack;

        #12;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ack", 32'(Ack), 32'd0);
        check("rst_rddata", RdData, 32'd0);
        check("rst_addrerr", 32'(AddrErr), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;

        xact(1'b1, 32'h10, 32'hDEADBEEF, 2'b00, 1'b0, rd, err, lat);
        check("st_word_lat", 32'(lat), 32'd3);
        check("st_word_rd0", rd, 32'd0);
        xact(1'b0, 32'h10, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("ld_word_lat", 32'(lat), 32'd3);
        check("ld_word", rd, 32'hDEADBEEF);
        check("ld_word_err", 32'(err), 32'd0);

        xact(1'b1, 32'h20, 32'h11223344, 2'b00, 1'b0, rd, err, lat);
        xact(1'b1, 32'h22, 32'h000000AA, 2'b10, 1'b0, rd, err, lat);
        xact(1'b0, 32'h20, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("byte_merge", rd, 32'h11AA3344);
        xact(1'b0, 32'h22, 32'd0, 2'b10, 1'b0, rd, err, lat);
        check("ld_byte_s", rd, 32'hFFFFFFAA);
        xact(1'b0, 32'h22, 32'd0, 2'b10, 1'b1, rd, err, lat);
        check("ld_byte_u", rd, 32'h000000AA);
        xact(1'b0, 32'h21, 32'd0, 2'b10, 1'b0, rd, err, lat);
        check("ld_byte1_s", rd, 32'h00000033);

        xact(1'b1, 32'h20, 32'h80015678, 2'b00, 1'b0, rd, err, lat);
        xact(1'b0, 32'h22, 32'd0, 2'b01, 1'b0, rd, err, lat);
        check("ld_half_hi_s", rd, 32'hFFFF8001);
        xact(1'b0, 32'h22, 32'd0, 2'b01, 1'b1, rd, err, lat);
        check("ld_half_hi_u", rd, 32'h00008001);
        xact(1'b0, 32'h20, 32'd0, 2'b01, 1'b0, rd, err, lat);
        check("ld_half_lo_s", rd, 32'h00005678);
        xact(1'b1, 32'h20, 32'h1234BEEF, 2'b01, 1'b0, rd, err, lat);
        xact(1'b0, 32'h20, 32'd0, 2'b11, 1'b0, rd, err, lat);
        check("half_merge", rd, 32'h8001BEEF);

        // Req toggling and address change while WAIT is in progress
        @(negedge Clk);
        Req = 1'b1; WrEn = 1'b0; Addr = 32'h10; Size = 2'b00; Unsigned = 1'b0;
        @(posedge Clk);
        #1 Addr = 32'h20;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(negedge Clk);
        Req = 1'b1;
        @(posedge Clk);
        #1 Req = 1'b0;
        ack_n = 0;
        first_ack = -1;
        rd = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk);
            #1;
            if (Ack) begin
                ack_n++;
                rd = RdData;
                if (first_ack < 0) first_ack = i;
            end
        end
        check("toggle_ack_count", 32'(ack_n), 32'd1);
        check("toggle_ack_pos", 32'(first_ack), 32'd0);
        check("toggle_addr_held", rd, 32'hDEADBEEF);

        // Reset during WAIT of a store aborts it
        xact(1'b1, 32'h30, 32'h12345678, 2'b00, 1'b0, rd, err, lat);
        @(negedge Clk);
        Req = 1'b1; WrEn = 1'b1; Addr = 32'h30; WrData = 32'h00000055; Size = 2'b00;
        @(posedge Clk);
        #1 Req = 1'b0;
        @(posedge Clk);
        #1 check("wait_busy", 32'(Busy), 32'd1);
        Rst = 1'b0;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_ack", 32'(Ack), 32'd0);
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        ack_n = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge Clk);
            #1 if (Ack) ack_n++;
        end
        check("abort_no_ack", 32'(ack_n), 32'd0);
        xact(1'b0, 32'h30, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("abort_mem_kept", rd, 32'h12345678);

        // First edge after reset release accepts a request
        @(posedge Clk);
        #1 Rst = 1'b0;
        #3 Rst = 1'b1;
        xact(1'b0, 32'h10, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_data", rd, 32'hDEADBEEF);

        // Misaligned accesses
        xact(1'b1, 32'h40, 32'h01020304, 2'b00, 1'b0, rd, err, lat);
        xact(1'b1, 32'h41, 32'hCAFEF00D, 2'b00, 1'b0, rd, err, lat);
`ifdef DMR_ALIGN_CHECK_EN
        check("mis_st_err", 32'(err), 32'd1);
        check("mis_st_rd", rd, 32'd0);
        xact(1'b0, 32'h40, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("mis_st_mem", rd, 32'h01020304);
        xact(1'b0, 32'h41, 32'd0, 2'b01, 1'b0, rd, err, lat);
        check("mis_ld_err", 32'(err), 32'd1);
        check("mis_ld_rd", rd, 32'd0);
`else
        check("mis_st_err", 32'(err), 32'd0);
        check("mis_st_rd", rd, 32'd0);
        xact(1'b0, 32'h40, 32'd0, 2'b00, 1'b0, rd, err, lat);
        check("mis_st_mem", rd, 32'hCAFEF00D);
        xact(1'b0, 32'h41, 32'd0, 2'b01, 1'b0, rd, err, lat);
        check("mis_ld_err", 32'(err), 32'd0);
        check("mis_ld_rd", rd, 32'hFFFFF00D);
`endif

        // Zero-wait instance with Req held for three back-to-back requests
        @(negedge Clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h8; wdata0 = 32'h00000077;
        ack_n = 0;
        for (int k = 0; k < 7; k++) begin
            @(posedge Clk);
            #1;
            if (k == 4) req0 = 1'b0;
            if (ack0) ack_n++;
            check($sformatf("b2b_ack_%0d", k), 32'(ack0), 32'((k <= 4) && (k % 2 == 0)));
            check($sformatf("b2b_busy_%0d", k), 32'(busy0), 32'((k <= 4) && (k % 2 == 0)));
        end
        check("b2b_ack_count", 32'(ack_n), 32'd3);
        @(negedge Clk);
        req0 = 1'b1; wr0 = 1'b0;
        @(posedge Clk);
        #1 req0 = 1'b0;
        check("w0_ld_ack", 32'(ack0), 32'd1);
        check("w0_ld_data", rd0, 32'h00000077);
        @(posedge Clk);
        #1 check("w0_idle_rd", rd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
